// File: rtl/pipe_ctrl_decoder.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_decoder
//
// Main control unit for the five-stage MIPS pipeline. It decodes the ID-stage
// opcode, picks the destination register, and carries the control word through
// the ID/EX, EX/MEM and MEM/WB registers. When an instruction in ID reads the
// register a load in EX will write, it stalls the front end for one cycle.
//
// Optional feature (macro DEC_BRANCH_EN):
//   BEQ decode and IF/ID flush on a taken branch resolved in EX.
//   When the macro is not defined:
//     - BEQ decodes as a NOP;
//     - branch_taken_i is ignored;
//     - ifid_flush_o is held at 0.
//
// Ports:
//   clk_i, rst_i               clock, asynchronous active-high reset
//   instr_valid_i, instr_op_i  ID-stage valid flag and opcode
//   rs_i, rt_i, rd_i           ID-stage register fields
//   branch_taken_i             taken branch resolved in EX
//   pc_write_o, ifid_write_o   front-end load enables (low while stalled)
//   ifid_flush_o               clear the IF/ID register
//   ex_alu_op_o, ex_alu_src_o, ex_branch_o   ID/EX control outputs
//   mem_read_o, mem_write_o                  EX/MEM control outputs
//   wb_reg_write_o, wb_mem_to_reg_o          MEM/WB write-back controls
//   wb_wreg_o                                MEM/WB destination register
//   stall_cnt_o                saturating count of load-use stall cycles
// ---------------------------------------------------------------------------
module pipe_ctrl_decoder #(
  parameter int ALUOP_W     = 6,
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   instr_valid_i,
  input  logic [5:0]             instr_op_i,
  input  logic [REG_ADDR_W-1:0]  rs_i,
  input  logic [REG_ADDR_W-1:0]  rt_i,
  input  logic [REG_ADDR_W-1:0]  rd_i,
  input  logic                   branch_taken_i,
  output logic                   pc_write_o,
  output logic                   ifid_write_o,
  output logic                   ifid_flush_o,
  output logic [ALUOP_W-1:0]     ex_alu_op_o,
  output logic                   ex_alu_src_o,
  output logic                   ex_branch_o,
  output logic                   mem_read_o,
  output logic                   mem_write_o,
  output logic                   wb_reg_write_o,
  output logic                   wb_mem_to_reg_o,
  output logic [REG_ADDR_W-1:0]  wb_wreg_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  // Raw opcode decode, before the valid / $0 qualification.
  logic [ALUOP_W-1:0] w_alu_op;
  logic w_alu_src, w_reg_dst, w_mem_read, w_mem_write;
  logic w_branch, w_reg_write, w_mem_to_reg, w_rt_src;

  always_comb begin
    w_alu_op     = '0;
    w_alu_src    = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_branch     = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_rt_src     = 1'b0;
    case (instr_op_i)
      OP_RTYPE: begin
        w_reg_dst = 1'b1; w_reg_write = 1'b1; w_rt_src = 1'b1;
      end
      OP_ADDI: begin
        w_alu_op = ALUOP_W'(3'd1); w_alu_src = 1'b1; w_reg_write = 1'b1;
      end
      OP_SLTIU: begin
        w_alu_op = ALUOP_W'(3'd2); w_alu_src = 1'b1; w_reg_write = 1'b1;
      end
      OP_ORI: begin
        w_alu_op = ALUOP_W'(3'd3); w_alu_src = 1'b1; w_reg_write = 1'b1;
      end
      OP_LW: begin
        w_alu_op = ALUOP_W'(3'd4); w_alu_src = 1'b1; w_mem_read = 1'b1;
        w_reg_write = 1'b1; w_mem_to_reg = 1'b1;
      end
      OP_SW: begin
        w_alu_op = ALUOP_W'(3'd5); w_alu_src = 1'b1; w_mem_write = 1'b1;
        w_rt_src = 1'b1;
      end
`ifdef DEC_BRANCH_EN
      OP_BEQ: begin
        w_alu_op = ALUOP_W'(3'd6); w_branch = 1'b1; w_rt_src = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Qualified control word. A write to $0 is dropped entirely so that
  // downstream forwarding/hazard logic never sees $0 as a producer.
  logic [REG_ADDR_W-1:0] w_wreg_raw;
  logic                  w_wr_keep;
  assign w_wreg_raw = w_reg_dst ? rd_i : rt_i;
  assign w_wr_keep  = instr_valid_i & w_reg_write & (w_wreg_raw != '0);

  // ID/EX, EX/MEM and MEM/WB state.
  logic [ALUOP_W-1:0]     r_ex_alu_op;
  logic                   r_ex_alu_src, r_ex_branch, r_ex_mem_read, r_ex_mem_write;
  logic                   r_ex_reg_write, r_ex_mem_to_reg;
  logic [REG_ADDR_W-1:0]  r_ex_wreg;
  logic                   r_mem_mem_read, r_mem_mem_write, r_mem_reg_write, r_mem_mem_to_reg;
  logic [REG_ADDR_W-1:0]  r_mem_wreg;
  logic                   r_wb_reg_write, r_wb_mem_to_reg;
  logic [REG_ADDR_W-1:0]  r_wb_wreg;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  // Load-use hazard against the instruction currently in EX.
  logic w_stall, w_flush, w_bubble, w_hold;
  assign w_stall = instr_valid_i & r_ex_mem_read & (r_ex_wreg != '0) &
                   ((r_ex_wreg == rs_i) | (w_rt_src & (r_ex_wreg == rt_i)));

`ifdef DEC_BRANCH_EN
  assign w_flush = branch_taken_i;
`else
  logic w_unused_branch;
  assign w_unused_branch = branch_taken_i;
  assign w_flush = 1'b0;
`endif

  // A flush overrides the stall: the stalled instruction is on the wrong
  // path anyway, so the front end keeps moving and the cycle is not counted.
  assign w_hold   = w_stall & ~w_flush;
  assign w_bubble = w_stall | w_flush;

  assign pc_write_o   = ~w_hold;
  assign ifid_write_o = ~w_hold;
  assign ifid_flush_o = w_flush;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ex_alu_op      <= '0;
      r_ex_alu_src     <= 1'b0;
      r_ex_branch      <= 1'b0;
      r_ex_mem_read    <= 1'b0;
      r_ex_mem_write   <= 1'b0;
      r_ex_reg_write   <= 1'b0;
      r_ex_mem_to_reg  <= 1'b0;
      r_ex_wreg        <= '0;
      r_mem_mem_read   <= 1'b0;
      r_mem_mem_write  <= 1'b0;
      r_mem_reg_write  <= 1'b0;
      r_mem_mem_to_reg <= 1'b0;
      r_mem_wreg       <= '0;
      r_wb_reg_write   <= 1'b0;
      r_wb_mem_to_reg  <= 1'b0;
      r_wb_wreg        <= '0;
      r_stall_cnt      <= '0;
    end else begin
      if (w_bubble || !instr_valid_i) begin
        r_ex_alu_op     <= '0;
        r_ex_alu_src    <= 1'b0;
        r_ex_branch     <= 1'b0;
        r_ex_mem_read   <= 1'b0;
        r_ex_mem_write  <= 1'b0;
        r_ex_reg_write  <= 1'b0;
        r_ex_mem_to_reg <= 1'b0;
        r_ex_wreg       <= '0;
      end else begin
        r_ex_alu_op     <= w_alu_op;
        r_ex_alu_src    <= w_alu_src;
        r_ex_branch     <= w_branch;
        r_ex_mem_read   <= w_mem_read;
        r_ex_mem_write  <= w_mem_write;
        r_ex_reg_write  <= w_wr_keep;
        r_ex_mem_to_reg <= w_mem_to_reg;
        r_ex_wreg       <= w_wr_keep ? w_wreg_raw : '0;
      end
      // Downstream stages never back-pressure.
      r_mem_mem_read   <= r_ex_mem_read;
      r_mem_mem_write  <= r_ex_mem_write;
      r_mem_reg_write  <= r_ex_reg_write;
      r_mem_mem_to_reg <= r_ex_mem_to_reg;
      r_mem_wreg       <= r_ex_wreg;
      r_wb_reg_write   <= r_mem_reg_write;
      r_wb_mem_to_reg  <= r_mem_mem_to_reg;
      r_wb_wreg        <= r_mem_wreg;
      if (w_hold && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign ex_alu_op_o     = r_ex_alu_op;
  assign ex_alu_src_o    = r_ex_alu_src;
  assign ex_branch_o     = r_ex_branch;
  assign mem_read_o      = r_mem_mem_read;
  assign mem_write_o     = r_mem_mem_write;
  assign wb_reg_write_o  = r_wb_reg_write;
  assign wb_mem_to_reg_o = r_wb_mem_to_reg;
  assign wb_wreg_o       = r_wb_wreg;
  assign stall_cnt_o     = r_stall_cnt;

endmodule

// File: doc/pipe_ctrl_decoder.md
# pipe_ctrl_decoder

Pipelined main control unit for the five-stage MIPS core. Decodes the ID-stage opcode into control bits, selects the destination register, and carries the control word through the ID/EX, EX/MEM and MEM/WB registers. Detects load-use hazards and stalls the front end. Optionally handles BEQ with branch flush. Sits between the IF/ID register and the datapath stage registers and replaces the single-cycle combinational decoder.

## Interface
- ALUOP_W, 6: ALU-op field width; must be ≥3; codes are zero-extended.
- REG_ADDR_W, 5: register-address width.
- STALL_CNT_W, 16: width of the stall-cycle counter.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high.
- instr_valid_i  in  1  the ID-stage instruction is valid.
- instr_op_i  in  6  opcode of the ID-stage instruction.
- rs_i, rt_i, rd_i  in  REG_ADDR_W  register fields of the ID-stage instruction.
- branch_taken_i  in  1  EX stage resolved a taken branch (used only with DEC_BRANCH_EN).
- pc_write_o  out  1  PC update enable.
- ifid_write_o  out  1  IF/ID register load enable.
- ifid_flush_o  out  1  zero the IF/ID register.
- ex_alu_op_o  out  ALUOP_W  EX-stage ALU-op code.
- ex_alu_src_o  out  1  EX-stage ALU source (1 selects the immediate).
- ex_branch_o  out  1  EX-stage branch bit.
- mem_read_o, mem_write_o  out  1  MEM-stage data-memory strobes.
- wb_reg_write_o, wb_mem_to_reg_o  out  1  WB-stage write-back controls.
- wb_wreg_o  out  REG_ADDR_W  WB-stage destination register.
- stall_cnt_o  out  STALL_CNT_W  saturating count of load-use stall cycles.

## Operation
- Opcode → {AluOp, AluSrc, RegDst, MemRead, MemWrite, Branch, RegWrite, MemToReg}:
  - 000000 R-type → 0, 0, 1, 0, 0, 0, 1, 0
  - 001000 ADDI → 1, 1, 0, 0, 0, 0, 1, 0
  - 001001 SLTIU → 2, 1, 0, 0, 0, 0, 1, 0
  - 001101 ORI → 3, 1, 0, 0, 0, 0, 1, 0
  - 100011 LW → 4, 1, 0, 1, 0, 0, 1, 1
  - 101011 SW → 5, 1, 0, 0, 1, 0, 0, 0
  - any other opcode → all zero (NOP).
- Destination register: wreg = RegDst ? rd_i : rt_i.
- If RegWrite=0 or wreg=0, the latched wreg and RegWrite are both 0.
- If instr_valid_i=0, the decoded word is forced to all zero.
- rt is a source for R-type, SW and BEQ only.
- Load-use stall: stall = instr_valid_i & ID/EX MemRead & ID/EX wreg≠0 & (ID/EX wreg==rs_i | (rt is a source & ID/EX wreg==rt_i)).
- On stall:
  - a zero bubble is loaded into ID/EX;
  - pc_write_o=0 and ifid_write_o=0;
  - stall_cnt_o increments and saturates at all-ones.
- Flush: with DEC_BRANCH_EN, branch_taken_i=1 forces ifid_flush_o=1, loads a bubble into ID/EX, and holds pc_write_o=1 and ifid_write_o=1.
- Flush has priority over stall; a flush cycle does not count as a stall.
- EX/MEM and MEM/WB advance every cycle with no back-pressure.
- pc_write_o, ifid_write_o and ifid_flush_o are combinational from the inputs and the ID/EX state.

## Timing
- Reset (asynchronous, any cycle):
  - all three stage registers and stall_cnt_o go to 0;
  - all ex_/mem_/wb_ outputs read 0;
  - pc_write_o=1, ifid_write_o=1, ifid_flush_o=0.
- Reset mid-stall: the bubble state is lost; operation resumes from empty pipeline registers.
- Latency for an instruction decoded in cycle N (captured at edge N):
  - ex_* valid in cycle N+1;
  - mem_* valid in cycle N+2;
  - wb_* valid in cycle N+3.
- A load followed immediately by a dependent instruction gives exactly one stall cycle. The dependent instruction is re-presented in the following cycle and passes, because ID/EX then holds a bubble.
- LW to $0 never stalls.
- Back-to-back dependent loads stall once per pair.

## Configuration
- DEC_BRANCH_EN defined:
  - opcode 000100 (BEQ) decodes to AluOp=6, Branch=1, all other bits 0, rt treated as a source;
  - branch_taken_i drives the flush behaviour.
- DEC_BRANCH_EN undefined:
  - 000100 decodes as NOP;
  - branch_taken_i is ignored;
  - ifid_flush_o is tied to 0.

## Test plan
- Reset asserted mid-stream → every ex_/mem_/wb_ output and stall_cnt_o read 0 asynchronously; pc_write_o=1.
- ADDI rt=3 in cycle 0 → ex_alu_op_o=1 and ex_alu_src_o=1 in cycle 1; wb_reg_write_o=1 and wb_wreg_o=3 in cycle 3.
- LW rt=5, then R-type rs=5 → one cycle with pc_write_o=0 and ifid_write_o=0; stall_cnt_o goes 0→1; the R-type reaches wb with wb_wreg_o equal to rd_i.
- LW rt=5, then ADDI rs=4 rt=5 → no stall, because rt is not a source for ADDI.
- DEC_BRANCH_EN with branch_taken_i=1 in the same cycle as a load-use stall → ifid_flush_o=1, pc_write_o=1, ID/EX loaded with a bubble, stall_cnt_o unchanged.
- Drive more than 2^STALL_CNT_W − 1 stall cycles → stall_cnt_o saturates at all-ones; R-type with rd=0 → wb_reg_write_o=0.
